// File: rtl/quad_lock_pkg.sv
// Shared types and helpers for the quad-key code lock.
package quad_lock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTRY   = 2'd1,
        OPEN    = 2'd2,
        LOCKOUT = 2'd3
    } lock_state_t;

    localparam int DIGIT_W    = 2;
    // Widest packed code supported (8 digits of DIGIT_W bits).
    localparam int CODE_MAX_W = 16;

    // Digit idx of a packed code; digit 0 sits in the low bits and is entered first.
    function automatic logic [DIGIT_W-1:0] code_digit(input logic [CODE_MAX_W-1:0] code,
                                                      input logic [2:0]            idx);
        return code[DIGIT_W*idx +: DIGIT_W];
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Saturating cycle timer with synchronous clear and a compare against a runtime limit.
module lock_timer
#(
    parameter int TMR_W = 24
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [TMR_W-1:0] limit,
    output logic [TMR_W-1:0] count,
    output logic             hit
);

    // Count up while enabled, stick at all-ones, clear wins over counting.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign hit = (count == limit);

endmodule

// File: rtl/quad_code_lock.sv
// Code lock fed by four debounced key pulses: digit sequence match, unlock hold,
// fail counting with lockout, and inter-key timeout.
module quad_code_lock
    import quad_lock_pkg::*;
#(
    parameter int                  CODE_LEN    = 4,
    parameter logic [2*CODE_LEN-1:0] CODE      = 8'b11_10_01_00,
    parameter int                  TMR_W       = 24,
    parameter logic [TMR_W-1:0]    TIMEOUT_CYC = 24'd5_000_000,
    parameter logic [TMR_W-1:0]    OPEN_CYC    = 24'd10_000_000,
    parameter logic [TMR_W-1:0]    LOCK_CYC    = 24'd15_000_000,
    parameter int                  MAX_FAIL    = 3
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       X0_deb,
    input  logic       X1_deb,
    input  logic       X2_deb,
    input  logic       X3_deb,
    output logic       unlocked,
    output logic       locked_out,
    output logic       fail_pulse,
    output logic       timeout_pulse,
    output logic [2:0] digit_cnt,
    output logic [2:0] fail_cnt
);

    localparam logic [CODE_MAX_W-1:0] CODE_EXT = CODE_MAX_W'(CODE);
    localparam logic [3:0]            LEN4     = 4'(CODE_LEN);
    localparam logic [2:0]            MAXF     = 3'(MAX_FAIL);

    lock_state_t      state, state_nxt;
    logic [2:0]       digit_nxt, fail_nxt, fail_inc, base_cnt;
    logic             mismatch, mm_nxt, base_mm, entry_mm;
    logic [3:0]       entry_len;
    logic             fail_p_nxt, to_p_nxt;
    logic [3:0]       keys;
    logic             key_ev;
    logic [1:0]       key_val;
    logic             tmr_clear, tmr_en, tmr_eq, tmr_hit;
    logic [TMR_W-1:0] tmr_cnt, tmr_limit;

    assign keys = {X3_deb, X2_deb, X1_deb, X0_deb};

    // A key event is exactly one key high; anything else is treated as no key.
    always_comb begin
        key_ev  = 1'b1;
        key_val = 2'd0;
        case (keys)
            4'b0001: key_val = 2'd0;
            4'b0010: key_val = 2'd1;
            4'b0100: key_val = 2'd2;
            4'b1000: key_val = 2'd3;
            default: key_ev  = 1'b0;
        endcase
    end

    // Per-state expiry limit for the shared timer.
    always_comb begin
        tmr_limit = '1;
        case (state)
            ENTRY:   tmr_limit = TIMEOUT_CYC - 1'b1;
            OPEN:    tmr_limit = OPEN_CYC - 1'b1;
            LOCKOUT: tmr_limit = LOCK_CYC - 1'b1;
            default: tmr_limit = '1;
        endcase
    end

    // Overshoot is treated as expired too, so a stale count can never skip the limit.
    assign tmr_hit   = tmr_eq || (tmr_cnt > tmr_limit);
    // Restart on every state change and on each accepted digit; idle needs no timing.
    assign tmr_clear = (state_nxt != state) || ((state == ENTRY) && key_ev);
    assign tmr_en    = (state != IDLE);

    lock_timer #(.TMR_W(TMR_W)) u_timer (
        .sysclk (sysclk),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (tmr_en),
        .limit  (tmr_limit),
        .count  (tmr_cnt),
        .hit    (tmr_eq)
    );

    // Next-state, digit/fail bookkeeping and pulse generation.
    always_comb begin
        state_nxt  = state;
        digit_nxt  = digit_cnt;
        fail_nxt   = fail_cnt;
        mm_nxt     = mismatch;
        fail_p_nxt = 1'b0;
        to_p_nxt   = 1'b0;
        fail_inc   = fail_cnt + 3'd1;
        // A fresh entry from IDLE starts with no digits and a clean mismatch flag.
        base_cnt   = (state == IDLE) ? 3'd0 : digit_cnt;
        base_mm    = (state == IDLE) ? 1'b0 : mismatch;
        entry_mm   = base_mm | (key_val != code_digit(CODE_EXT, base_cnt));
        entry_len  = {1'b0, base_cnt} + 4'd1;

        case (state)
            IDLE, ENTRY: begin
                if (key_ev) begin
                    if (entry_len == LEN4) begin
                        digit_nxt = 3'd0;
                        mm_nxt    = 1'b0;
                        if (!entry_mm) begin
                            state_nxt = OPEN;
                            fail_nxt  = 3'd0;
                        end else begin
                            fail_p_nxt = 1'b1;
                            fail_nxt   = fail_inc;
                            state_nxt  = (fail_inc == MAXF) ? LOCKOUT : IDLE;
                        end
                    end else begin
                        digit_nxt = entry_len[2:0];
                        mm_nxt    = entry_mm;
                        state_nxt = ENTRY;
                    end
                end else if ((state == ENTRY) && tmr_hit) begin
                    to_p_nxt  = 1'b1;
                    state_nxt = IDLE;
                    digit_nxt = 3'd0;
                    mm_nxt    = 1'b0;
                end
            end
            OPEN: begin
                // Any key relocks and is swallowed.
                if (key_ev || tmr_hit) state_nxt = IDLE;
            end
            LOCKOUT: begin
                if (tmr_hit) begin
                    state_nxt = IDLE;
                    fail_nxt  = 3'd0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            digit_cnt     <= 3'd0;
            fail_cnt      <= 3'd0;
            mismatch      <= 1'b0;
            fail_pulse    <= 1'b0;
            timeout_pulse <= 1'b0;
            unlocked      <= 1'b0;
            locked_out    <= 1'b0;
        end else begin
            state         <= state_nxt;
            digit_cnt     <= digit_nxt;
            fail_cnt      <= fail_nxt;
            mismatch      <= mm_nxt;
            fail_pulse    <= fail_p_nxt;
            timeout_pulse <= to_p_nxt;
            unlocked      <= (state_nxt == OPEN);
            locked_out    <= (state_nxt == LOCKOUT);
        end
    end

endmodule

// File: tb/tb_quad_code_lock.sv
// Directed bench for quad_code_lock with short timer limits.
module tb_quad_code_lock;

    logic       sysclk;
    logic       reset;
    logic       X0_deb, X1_deb, X2_deb, X3_deb;
    logic       unlocked, locked_out, fail_pulse, timeout_pulse;
    logic [2:0] digit_cnt, fail_cnt;

    int total = 0;
    int bad   = 0;

    quad_code_lock #(
        .CODE_LEN    (4),
        .CODE        (8'b11_10_01_00),
        .TMR_W       (24),
        .TIMEOUT_CYC (24'd20),
        .OPEN_CYC    (24'd10),
        .LOCK_CYC    (24'd30),
        .MAX_FAIL    (3)
    ) dut (
        .sysclk        (sysclk),
        .reset         (reset),
        .X0_deb        (X0_deb),
        .X1_deb        (X1_deb),
        .X2_deb        (X2_deb),
        .X3_deb        (X3_deb),
        .unlocked      (unlocked),
        .locked_out    (locked_out),
        .fail_pulse    (fail_pulse),
        .timeout_pulse (timeout_pulse),
        .digit_cnt     (digit_cnt),
        .fail_cnt      (fail_cnt)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input int n);
        {X3_deb, X2_deb, X1_deb, X0_deb} = 4'b0001 << n;
        tick();
        {X3_deb, X2_deb, X1_deb, X0_deb} = 4'b0000;
    endtask

    task automatic entry(input int a, input int b, input int c, input int d);
        press(a); press(b); press(c); press(d);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_unl"}, int'(unlocked), 0);
        chk({tag, "_lck"}, int'(locked_out), 0);
        chk({tag, "_fp"},  int'(fail_pulse), 0);
        chk({tag, "_tp"},  int'(timeout_pulse), 0);
        chk({tag, "_dc"},  int'(digit_cnt), 0);
        chk({tag, "_fc"},  int'(fail_cnt), 0);
    endtask

    // Hard stop if the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        {X3_deb, X2_deb, X1_deb, X0_deb} = 4'b0000;
        idle(3);
        chk_all_zero("rst");
        reset = 1'b1;
        tick();

        // 1: correct code, unlock held 10 cycles
        press(0); chk("s1_dc1", int'(digit_cnt), 1);
        idle(4); press(1);
        idle(4); press(2); chk("s1_dc3", int'(digit_cnt), 3);
        idle(4); press(3);
        chk("s1_unl", int'(unlocked), 1);
        chk("s1_dc0", int'(digit_cnt), 0);
        chk("s1_fc",  int'(fail_cnt), 0);
        idle(9);  chk("s1_hold", int'(unlocked), 1);
        idle(1);  chk("s1_drop", int'(unlocked), 0);

        // 2: wrong order
        entry(0, 1, 3, 2);
        chk("s2_fp",  int'(fail_pulse), 1);
        chk("s2_fc",  int'(fail_cnt), 1);
        chk("s2_unl", int'(unlocked), 0);
        chk("s2_dc",  int'(digit_cnt), 0);
        tick();
        chk("s2_fp_end", int'(fail_pulse), 0);

        // 3: reach lockout, keys ignored, lockout lasts 30 cycles
        entry(3, 3, 3, 3);
        chk("s3_fc2", int'(fail_cnt), 2);
        chk("s3_lck0", int'(locked_out), 0);
        entry(0, 0, 0, 0);
        chk("s3_fc3", int'(fail_cnt), 3);
        chk("s3_lck", int'(locked_out), 1);
        chk("s3_fp",  int'(fail_pulse), 1);
        entry(0, 1, 2, 3);
        chk("s3_unl", int'(unlocked), 0);
        chk("s3_dc",  int'(digit_cnt), 0);
        idle(25);
        chk("s3_lck_end", int'(locked_out), 1);
        chk("s3_fc_hold", int'(fail_cnt), 3);
        idle(1);
        chk("s3_lck_off", int'(locked_out), 0);
        chk("s3_fc_clr",  int'(fail_cnt), 0);

        // 4: timeout keeps fail count
        entry(1, 1, 1, 1);
        chk("s4_fc1", int'(fail_cnt), 1);
        press(0); press(1);
        idle(19);
        chk("s4_tp_early", int'(timeout_pulse), 0);
        chk("s4_dc2",      int'(digit_cnt), 2);
        idle(1);
        chk("s4_tp",  int'(timeout_pulse), 1);
        chk("s4_dc0", int'(digit_cnt), 0);
        chk("s4_fc",  int'(fail_cnt), 1);
        entry(0, 1, 2, 3);
        chk("s4_unl", int'(unlocked), 1);
        chk("s4_fc0", int'(fail_cnt), 0);
        idle(10);
        chk("s4_unl_off", int'(unlocked), 0);

        // 5: two keys at once are ignored and do not restart the timer
        press(0); press(1);
        idle(10);
        {X3_deb, X2_deb, X1_deb, X0_deb} = 4'b0101;
        tick();
        {X3_deb, X2_deb, X1_deb, X0_deb} = 4'b0000;
        chk("s5_dc", int'(digit_cnt), 2);
        idle(8);
        chk("s5_tp_early", int'(timeout_pulse), 0);
        idle(1);
        chk("s5_tp", int'(timeout_pulse), 1);
        entry(0, 1, 2, 3);
        chk("s5_unl", int'(unlocked), 1);
        idle(2);
        press(3);
        chk("s5_relock", int'(unlocked), 0);
        chk("s5_dc0",    int'(digit_cnt), 0);
        tick();
        chk("s5_dc_stay", int'(digit_cnt), 0);

        // 6: async reset mid-entry
        entry(2, 2, 2, 2);
        press(0); press(1);
        chk("s6_pre_dc", int'(digit_cnt), 2);
        chk("s6_pre_fc", int'(fail_cnt), 1);
        #3;
        reset = 1'b0;
        #1;
        chk_all_zero("s6_rst");
        #2;
        reset = 1'b1;
        tick();
        entry(0, 1, 2, 3);
        chk("s6_unl", int'(unlocked), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/quad_code_lock.md
Name: quad_code_lock

Overview:
- Consumes the four single-cycle debounced key pulses (X0_deb..X3_deb) produced by the quad debouncer and recognises a fixed CODE_LEN-digit entry sequence.
- Drives an unlock output, a fail counter with lockout, and an inter-key timeout.
- Sits downstream of the debouncer in the F5 button-input path. Runs on sysclk only, with no heartbeat dependency.

Parameters:
- CODE_LEN, 4, number of digits per entry (2..8).
- CODE, 8'b11_10_01_00, packed code; digit i is CODE[2i+1:2i]; digit 0 is entered first (default sequence is 0,1,2,3).
- TMR_W, 24, width of the shared cycle timer.
- TIMEOUT_CYC, 24'd5_000_000, idle sysclk cycles after a key before an entry is aborted.
- OPEN_CYC, 24'd10_000_000, cycles the unlocked output is held.
- LOCK_CYC, 24'd15_000_000, lockout duration in cycles.
- MAX_FAIL, 3, consecutive failed entries that trigger lockout (1..7).

Ports:
- sysclk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- X0_deb  input  1  debounced key 0 pulse, one cycle per press.
- X1_deb  input  1  key 1 pulse.
- X2_deb  input  1  key 2 pulse.
- X3_deb  input  1  key 3 pulse.
- unlocked  output  1  high while in OPEN.
- locked_out  output  1  high while in LOCKOUT.
- fail_pulse  output  1  one-cycle pulse when a complete wrong entry is rejected.
- timeout_pulse  output  1  one-cycle pulse when a partial entry is aborted by timeout.
- digit_cnt  output  3  digits accepted in the current entry.
- fail_cnt  output  3  consecutive failed entries.

Behaviour:
- Reset (async, reset=0): state IDLE. All outputs 0. Timer 0. Mismatch flag 0.
- Key event: exactly one Xn_deb high in a cycle. The digit value is n.
  - Zero or more than one high means no event. Such cycles are ignored and do not restart the timer.
- All outputs are registered. Any response appears one cycle after the triggering key or timer cycle.
- IDLE:
  - On a key event: mismatch <= (n != digit 0); digit_cnt <= 1; timer <= 0; go to ENTRY.
  - If CODE_LEN digits are already complete, apply the ENTRY completion rule instead.
- ENTRY:
  - On a key event: mismatch <= mismatch | (n != digit[digit_cnt]); digit_cnt++; timer <= 0.
  - With no key, the timer increments.
- ENTRY completion, evaluated when the key making digit_cnt == CODE_LEN is accepted:
  - No mismatch: go to OPEN, fail_cnt <= 0, timer <= 0.
  - Mismatch: pulse fail_pulse and fail_cnt++.
    - If the new fail_cnt == MAX_FAIL: go to LOCKOUT, timer <= 0.
    - Otherwise: go to IDLE.
  - In both cases digit_cnt <= 0 and mismatch <= 0.
- Timeout: in ENTRY, when the timer reaches TIMEOUT_CYC-1 without a key:
  - Pulse timeout_pulse, go to IDLE, digit_cnt <= 0.
  - fail_cnt is unchanged.
  - A key arriving in the same cycle wins, and no timeout occurs.
- OPEN:
  - unlocked = 1.
  - Returns to IDLE when the timer reaches OPEN_CYC-1.
  - Any key event returns to IDLE immediately (relock). That key is consumed and does not start an entry.
- LOCKOUT:
  - locked_out = 1. All keys are ignored.
  - When the timer reaches LOCK_CYC-1: go to IDLE, fail_cnt <= 0.
- Timer: saturates at all-ones and is never used wider than TMR_W. It is cleared on every state change.
- Reset asserted mid-entry, mid-OPEN or mid-LOCKOUT immediately forces the IDLE reset values.

Decomposition:
- Package quad_lock_pkg:
  - state enum {IDLE, ENTRY, OPEN, LOCKOUT}.
  - DIGIT_W=2.
  - A function extracting digit i from CODE.
- Sub-module lock_timer (TMR_W), which is natural to split out:
  - Inputs: clear, enable.
  - Outputs: count and a compare-equal flag against a runtime limit input.
  - Same sysclk and async active-low reset.
- The FSM and key one-hot validation stay in the top level.

Test Plan:
All scenarios use CODE_LEN=4, CODE=8'b11_10_01_00, TIMEOUT_CYC=20, OPEN_CYC=10, LOCK_CYC=30, MAX_FAIL=3.
1. Keys 0,1,2,3, each 5 cycles apart -> unlocked rises one cycle after the key-3 pulse, holds 10 cycles, then falls; fail_cnt=0.
2. Keys 0,1,3,2 -> fail_pulse for 1 cycle after the 4th key; fail_cnt=1; state IDLE; unlocked stays 0.
3. Three wrong 4-key entries -> fail_cnt=3; locked_out=1 for 30 cycles; a correct sequence during lockout leaves unlocked=0; after lockout, fail_cnt=0.
4. Keys 0,1 then 20 idle cycles -> timeout_pulse; digit_cnt=0; fail_cnt unchanged; then 0,1,2,3 -> unlocked.
5. X0_deb and X2_deb high in the same cycle mid-entry -> ignored; digit_cnt unchanged; timer not cleared. A key in OPEN -> unlocked drops the next cycle and digit_cnt stays 0.
6. Assert reset=0 asynchronously between clock edges during ENTRY with digit_cnt=2 -> all outputs 0 immediately; after release, 0,1,2,3 unlocks normally.
